// File: rtl/conv_pkg.sv
// ---------------------------------------------------------------------------
// conv_pkg
// Shared definitions for the 3x3 convolution datapath: default pixel width,
// kernel geometry and the bit placement of window elements inside a packed
// window bus. The convolution core uses the same helper, so both sides agree
// on element order.
// ---------------------------------------------------------------------------
package conv_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int KSIZE      = 3;
    localparam int WIN_N      = KSIZE * KSIZE;

    // Bit offset of window element k (k = row*KSIZE + col, row 0 = oldest line).
    function automatic int win_bit_off(input int k, input int data_w);
        return k * data_w;
    endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// ---------------------------------------------------------------------------
// conv_line_buffer
// One image line of pixel storage. The read is combinational, so the old
// contents at 'addr' are visible in the same cycle the new pixel is written
// (read-before-write). The contents are not reset.
//
// Ports:
//   clk      clock
//   wr_en    write strobe (one pixel per accepted beat)
//   addr     column address, also used for the read port
//   wr_data  pixel to store at addr
//   rd_data  current contents at addr
// ---------------------------------------------------------------------------
module conv_line_buffer
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 64,
    localparam int AW    = $clog2(IMG_W)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [IMG_W];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[addr];

endmodule

// File: rtl/conv_window_gen.sv
// ---------------------------------------------------------------------------
// conv_window_gen
// Turns a raster-order pixel stream into 3x3 windows for the convolution
// core. Two line buffers hold the previous two lines; three 3-deep shift rows
// form the window. One window is emitted per interior position
// (row>=2, col>=2) through a single output register stage.
//
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   in_pixel      incoming pixel
//   in_valid      in_pixel / in_sof valid
//   in_sof        first pixel of a frame (qualified by in_valid)
//   in_ready      beat accepted this cycle when in_valid is also high
//   win_data      packed window, element k at [k*DATA_W +: DATA_W]
//   win_valid     win_data holds a window
//   win_ready     downstream accepts the window
//   win_last      final window of the frame (with win_valid)
//   sof_misalign  one-cycle pulse: in_sof accepted away from position (0,0)
// ---------------------------------------------------------------------------
module conv_window_gen
    import conv_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_W-1:0]       in_pixel,
    input  logic                    in_valid,
    input  logic                    in_sof,
    output logic                    in_ready,
    output logic [WIN_N*DATA_W-1:0] win_data,
    output logic                    win_valid,
    input  logic                    win_ready,
    output logic                    win_last,
    output logic                    sof_misalign
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_MAX = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN_WIN = CW'(KSIZE - 1);
    localparam logic [RW-1:0] ROW_MIN_WIN = RW'(KSIZE - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;

    // win_q[r][c]: r=0 top (row-2), c=0 leftmost (oldest column)
    logic [KSIZE-1:0][KSIZE-1:0][DATA_W-1:0] win_q, win_d;

    logic [WIN_N*DATA_W-1:0] win_data_q, win_data_d;
    logic                    win_valid_q, win_valid_d;
    logic                    win_last_q, win_last_d;
    logic                    sof_misalign_q, sof_misalign_d;

    // ------------------------------------------------------------------
    // Handshake and position
    // ------------------------------------------------------------------
    logic          accept;
    logic [RW-1:0] pos_row;
    logic [CW-1:0] pos_col;
    logic          emit;

    logic [DATA_W-1:0] lb0_rd, lb1_rd;
    logic [KSIZE-1:0][DATA_W-1:0] new_col;
    logic [WIN_N*DATA_W-1:0] win_pack;

    // rst is included so the source sees not-ready while reset is held.
    assign in_ready = !rst && (!win_valid_q || win_ready);
    assign accept   = in_valid && in_ready;

    // An accepted sof pins this beat to (0,0) whatever the counters say.
    assign pos_row = (in_sof) ? '0 : row_q;
    assign pos_col = (in_sof) ? '0 : col_q;

    // col>=2 gating keeps windows from mixing the end of one line with
    // the start of the next.
    assign emit = accept && (pos_row >= ROW_MIN_WIN) && (pos_col >= COL_MIN_WIN);

    always_comb begin
        row_d = row_q;
        col_d = col_q;
        if (accept) begin
            if (pos_col == COL_MAX) begin
                col_d = '0;
                row_d = (pos_row == ROW_MAX) ? '0 : pos_row + RW'(1);
            end else begin
                col_d = pos_col + CW'(1);
                row_d = pos_row;
            end
        end
    end

    assign sof_misalign_d = accept && in_sof && ((row_q != '0) || (col_q != '0));

    // ------------------------------------------------------------------
    // Line buffers: LB0 holds line row-1, LB1 holds line row-2. Both are
    // read at the current column before being overwritten.
    // ------------------------------------------------------------------
    conv_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_lb0 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (pos_col),
        .wr_data (in_pixel),
        .rd_data (lb0_rd)
    );

    conv_line_buffer #(
        .DATA_W (DATA_W),
        .IMG_W  (IMG_W)
    ) u_lb1 (
        .clk     (clk),
        .wr_en   (accept),
        .addr    (pos_col),
        .wr_data (lb0_rd),
        .rd_data (lb1_rd)
    );

    // ------------------------------------------------------------------
    // Window shift rows
    // ------------------------------------------------------------------
    assign new_col[0] = lb1_rd;
    assign new_col[1] = lb0_rd;
    assign new_col[2] = in_pixel;

    always_comb begin
        win_d = win_q;
        if (accept) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    win_d[r][c] = win_q[r][c+1];
                end
                win_d[r][KSIZE-1] = new_col[r];
            end
        end
    end

    // Post-shift window flattened into core element order.
    always_comb begin
        win_pack = '0;
        for (int k = 0; k < WIN_N; k++) begin
            win_pack[win_bit_off(k, DATA_W) +: DATA_W] = win_d[k / KSIZE][k % KSIZE];
        end
    end

    // ------------------------------------------------------------------
    // Output register: reloads on emit (also when the previous window is
    // leaving the same cycle), clears on handshake otherwise, holds on stall.
    // ------------------------------------------------------------------
    always_comb begin
        win_valid_d = win_valid_q;
        win_data_d  = win_data_q;
        win_last_d  = win_last_q;
        if (emit) begin
            win_valid_d = 1'b1;
            win_data_d  = win_pack;
            win_last_d  = (pos_row == ROW_MAX) && (pos_col == COL_MAX);
        end else if (win_ready) begin
            win_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q          <= '0;
            col_q          <= '0;
            win_q          <= '0;
            win_data_q     <= '0;
            win_valid_q    <= 1'b0;
            win_last_q     <= 1'b0;
            sof_misalign_q <= 1'b0;
        end else begin
            row_q          <= row_d;
            col_q          <= col_d;
            win_q          <= win_d;
            win_data_q     <= win_data_d;
            win_valid_q    <= win_valid_d;
            win_last_q     <= win_last_d;
            sof_misalign_q <= sof_misalign_d;
        end
    end

    assign win_data     = win_data_q;
    assign win_valid    = win_valid_q;
    assign win_last     = win_last_q;
    assign sof_misalign = sof_misalign_q;

endmodule

// File: tb/tb_conv_window_gen.sv
// ---------------------------------------------------------------------------
// tb_conv_window_gen
// Randomized bench for conv_window_gen (5x4 image). A reference model keeps
// the current frame as a 2-D pixel array and builds each expected window
// directly from image coordinates.
// ---------------------------------------------------------------------------
module tb_conv_window_gen;

    localparam int DW = 8;
    localparam int W  = 5;
    localparam int H  = 4;
    localparam int WB = 9 * DW;

    // Reference windows (k8 .. k0, most significant byte first)
    localparam logic [WB-1:0] WIN_FIRST  = 72'h22_21_20_12_11_10_02_01_00;
    localparam logic [WB-1:0] WIN_SECOND = 72'h23_22_21_13_12_11_03_02_01;
    localparam logic [WB-1:0] WIN_LAST   = 72'h34_33_32_24_23_22_14_13_12;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] in_pixel;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic [WB-1:0] win_data;
    logic          win_valid;
    logic          win_ready;
    logic          win_last;
    logic          sof_misalign;

    conv_window_gen #(
        .DATA_W (DW),
        .IMG_W  (W),
        .IMG_H  (H)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .in_pixel     (in_pixel),
        .in_valid     (in_valid),
        .in_sof       (in_sof),
        .in_ready     (in_ready),
        .win_data     (win_data),
        .win_valid    (win_valid),
        .win_ready    (win_ready),
        .win_last     (win_last),
        .sof_misalign (sof_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] pix;
        logic          sof;
    } beat_t;

    typedef struct {
        logic [WB-1:0] data;
        logic          last;
    } win_t;

    beat_t         beats[$];
    win_t          exp_q[$];
    logic [WB-1:0] log_q[$];
    logic          last_log[$];

    // reference model state
    logic [DW-1:0] img [H][W];
    int            mrow, mcol;
    logic          mis_exp;

    int n_vec, n_err;
    int n_acc_run, n_mis, n_stall, first_win_acc;

    task automatic chk(input string tag, input logic [WB-1:0] got, input logic [WB-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        mrow    = 0;
        mcol    = 0;
        mis_exp = 1'b0;
    endtask

    task automatic model_accept(input logic [DW-1:0] pix, input logic sof);
        logic [WB-1:0] d;
        n_acc_run++;
        if (sof) begin
            mis_exp = (mrow != 0) || (mcol != 0);
            mrow    = 0;
            mcol    = 0;
        end
        img[mrow][mcol] = pix;
        if (mrow >= 2 && mcol >= 2) begin
            d = '0;
            for (int k = 0; k < 9; k++) d[k*DW +: DW] = img[mrow-2+k/3][mcol-2+k%3];
            exp_q.push_back('{data: d, last: (mrow == H-1) && (mcol == W-1)});
            if (first_win_acc < 0) first_win_acc = n_acc_run;
        end
        mcol++;
        if (mcol == W) begin
            mcol = 0;
            mrow = (mrow == H-1) ? 0 : mrow + 1;
        end
    endtask

    // Called at the falling edge: checks outputs, then models the coming edge.
    task automatic monitor();
        bit vexp, rdy_exp, acc;
        vexp    = exp_q.size() > 0;
        rdy_exp = !vexp || win_ready;
        acc     = in_valid && rdy_exp;
        chk("win_valid", WB'(win_valid), WB'(vexp));
        if (vexp) begin
            chk("win_data", win_data, exp_q[0].data);
            chk("win_last", WB'(win_last), WB'(exp_q[0].last));
        end
        chk("in_ready", WB'(in_ready), WB'(rdy_exp));
        chk("sof_misalign", WB'(sof_misalign), WB'(mis_exp));
        if (sof_misalign) n_mis++;
        if (!in_ready) n_stall++;
        if (vexp && win_ready) begin
            log_q.push_back(exp_q[0].data);
            last_log.push_back(exp_q[0].last);
            exp_q.pop_front();
        end
        mis_exp = 1'b0;
        if (acc) begin
            model_accept(in_pixel, in_sof);
            beats.pop_front();
        end
    endtask

    task automatic add_frame(input bit sof, input bit rnd);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                beats.push_back('{pix: rnd ? DW'($urandom) : DW'(r*16 + c),
                                  sof: sof && r == 0 && c == 0});
    endtask

    // Streams the queued beats. hold_n: win_ready forced low for that many
    // cycles after the first window is taken. max_acc: stop after that many
    // accepts (0 = run to completion).
    task automatic run(input int vpct, input int rpct, input int hold_n, input int max_acc);
        int cyc, hold;
        cyc           = 0;
        hold          = -1;
        n_acc_run     = 0;
        n_mis         = 0;
        n_stall       = 0;
        first_win_acc = -1;
        log_q.delete();
        last_log.delete();
        while ((beats.size() > 0 || exp_q.size() > 0) &&
               (max_acc == 0 || n_acc_run < max_acc) && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
            in_valid = (beats.size() > 0) && ($urandom_range(0, 99) < vpct);
            if (in_valid) begin
                in_pixel = beats[0].pix;
                in_sof   = beats[0].sof;
            end else begin
                in_pixel = DW'($urandom);
                in_sof   = 1'($urandom);   // must be ignored when not valid
            end
            if (hold > 0) begin
                win_ready = 1'b0;
                hold--;
            end else begin
                win_ready = $urandom_range(0, 99) < rpct;
            end
            @(negedge clk);
            monitor();
            if (hold_n > 0 && hold == -1 && log_q.size() == 1) hold = hold_n;
        end
        if (cyc >= 2000) chk("timeout", WB'(1), WB'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        #1;
        chk("rst_async_valid", WB'(win_valid), WB'(0));
        model_reset();
        repeat (2) begin
            @(negedge clk);
            chk("rst_valid", WB'(win_valid), WB'(0));
            chk("rst_ready", WB'(in_ready), WB'(0));
            chk("rst_data", win_data, '0);
            chk("rst_last", WB'(win_last), WB'(0));
            chk("rst_misalign", WB'(sof_misalign), WB'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        int nl;
        n_vec     = 0;
        n_err     = 0;
        in_pixel  = '0;
        win_ready = 1'b1;
        #2;
        do_reset();

        // basic window
        add_frame(1, 0);
        run(100, 100, 0, 0);
        chk("basic_count", WB'(log_q.size()), WB'(6));
        if (log_q.size() == 6) begin
            chk("basic_first", log_q[0], WIN_FIRST);
            chk("basic_last_win", log_q[5], WIN_LAST);
            nl = 0;
            foreach (last_log[i]) nl += int'(last_log[i]);
            chk("basic_nlast", WB'(nl), WB'(1));
            chk("basic_last_flag", WB'(last_log[5]), WB'(1));
        end
        chk("basic_first_acc", WB'(first_win_acc), WB'(13));

        // throughput: two frames back to back
        add_frame(1, 0);
        add_frame(1, 0);
        run(100, 100, 0, 0);
        chk("thru_stalls", WB'(n_stall), WB'(0));
        chk("thru_count", WB'(log_q.size()), WB'(12));
        if (log_q.size() == 12) chk("thru_f2_first", log_q[6], WIN_FIRST);

        // backpressure
        add_frame(1, 0);
        run(100, 100, 5, 0);
        chk("bp_stalls", WB'(n_stall), WB'(5));
        chk("bp_count", WB'(log_q.size()), WB'(6));
        if (log_q.size() == 6) chk("bp_win2", log_q[1], WIN_SECOND);

        // reset mid-frame, then a frame without sof
        add_frame(1, 0);
        run(100, 100, 0, 7);
        chk("mid_acc", WB'(n_acc_run), WB'(7));
        beats.delete();
        do_reset();
        add_frame(0, 0);
        run(100, 100, 0, 0);
        chk("rst_count", WB'(log_q.size()), WB'(6));
        chk("rst_first_acc", WB'(first_win_acc), WB'(13));
        if (log_q.size() == 6) chk("rst_first", log_q[0], WIN_FIRST);

        // sof on the 4th pixel
        for (int i = 0; i < 3; i++) beats.push_back('{pix: DW'(8'hA0 + i), sof: i == 0});
        add_frame(1, 0);
        run(100, 100, 0, 0);
        chk("mis_pulses", WB'(n_mis), WB'(1));
        chk("mis_first_acc", WB'(first_win_acc), WB'(16));
        chk("mis_count", WB'(log_q.size()), WB'(6));
        if (log_q.size() == 6) chk("mis_first", log_q[0], WIN_FIRST);

        // random stall mix with random pixel data
        for (int f = 0; f < 4; f++) begin
            add_frame(1, 1);
            run(60, 60, 0, 0);
            chk("mix_count", WB'(log_q.size()), WB'(6));
            if (log_q.size() == 6) chk("mix_last_flag", WB'(last_log[5]), WB'(1));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
